// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: gates byte loads into the serializer, sequences
// start / data / optional parity / stop bits and owns the TX line mux.
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  ser_data,
  input  logic                  ser_done,
  output logic                  ser_load,
  output logic                  ser_en,
  output logic                  TX_OUT,
  output logic                  busy,
  output logic                  ready,
  output logic                  frame_err,
  output logic [2:0]            o_dbg_state
);

  // Handshake: a request is taken on any CLK edge where Data_Valid and ready are
  // both high; Data_Valid while ready is low is dropped and never reaches ser_load.

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t     r_state;
  logic       r_par_en;
  logic       r_par_bit;
  logic [2:0] r_bit_cnt;
  logic       w_accept;
  logic       w_last_bit;

  assign ready       = (r_state == S_IDLE) || (r_state == S_STOP);
  assign w_accept    = Data_Valid && ready;
  assign ser_load    = w_accept;
  assign ser_en      = (r_state == S_START) || (r_state == S_DATA);
  assign busy        = (r_state != S_IDLE);
  // A missing ser_done on the eighth data bit still ends the data phase.
  assign w_last_bit  = ser_done || (r_bit_cnt == 3'd7);
  assign frame_err   = (r_state == S_DATA) && (r_bit_cnt == 3'd7) && !ser_done;
  assign o_dbg_state = r_state;

  always_comb begin
    TX_OUT = 1'b1;
    case (r_state)
      S_START:  TX_OUT = 1'b0;
      S_DATA:   TX_OUT = ser_data;
      S_PARITY: TX_OUT = r_par_bit;
      default:  TX_OUT = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state   <= S_IDLE;
      r_par_en  <= 1'b0;
      r_par_bit <= 1'b0;
      r_bit_cnt <= 3'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) r_state <= S_START;
        end
        S_START: begin
          r_state <= S_DATA;
        end
        S_DATA: begin
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (w_last_bit) r_state <= r_par_en ? S_PARITY : S_STOP;
        end
        S_PARITY: begin
          r_state <= S_STOP;
        end
        S_STOP: begin
          r_state <= w_accept ? S_START : S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
      // Frame configuration is captured only at accept so mid-frame changes are ignored.
      if (w_accept) begin
        r_par_en  <= PAR_EN;
        r_par_bit <= (^P_DATA) ^ PAR_TYP;
        r_bit_cnt <= 3'd0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl with a behavioural serializer; a scoreboard holds one
// expected {TX_OUT, ser_en, frame_err} row per busy cycle.
module tb_uart_tx_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] P_DATA = 8'h00;
  logic       Data_Valid = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       ser_data;
  logic       ser_done;
  logic       ser_load;
  logic       ser_en;
  logic       TX_OUT;
  logic       busy;
  logic       ready;
  logic       frame_err;
  logic [2:0] o_dbg_state;

  int total = 0;
  int bad = 0;
  int load_cnt = 0;
  int exp_loads = 0;
  int fe_cnt = 0;
  logic mon_en = 1'b0;
  logic stub_mode = 1'b0;
  logic [2:0] exp_q[$];

  uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .ser_data(ser_data), .ser_done(ser_done),
    .ser_load(ser_load), .ser_en(ser_en), .TX_OUT(TX_OUT), .busy(busy),
    .ready(ready), .frame_err(frame_err), .o_dbg_state(o_dbg_state)
  );

  always #5 CLK = ~CLK;

  // Serializer: registered output, LSB first, done flagged with bit 7.
  logic [7:0] s_reg;
  logic [2:0] s_cnt;
  logic       s_data;
  logic       s_done;
  always_ff @(posedge CLK) begin
    if (!RST) begin
      s_reg <= 8'h00; s_cnt <= 3'd0; s_data <= 1'b0; s_done <= 1'b0;
    end else if (ser_load) begin
      s_reg <= P_DATA; s_cnt <= 3'd0; s_done <= 1'b0;
    end else if (ser_en) begin
      s_data <= s_reg[s_cnt];
      s_cnt  <= s_cnt + 3'd1;
      s_done <= (s_cnt == 3'd7);
    end else begin
      s_done <= 1'b0;
    end
  end
  assign ser_data = s_data;
  assign ser_done = s_done && !stub_mode;

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", name, got, want);
    end
  endtask

  // Monitor: pops one row per busy cycle; idle cycles must show a quiet line.
  always @(negedge CLK) begin
    if (mon_en) begin
      if (ser_load) load_cnt++;
      if (frame_err) fe_cnt++;
      if (busy) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sb_extra: busy with empty queue tx=%b", TX_OUT);
        end else begin
          logic [2:0] row;
          row = exp_q.pop_front();
          if ({TX_OUT, ser_en, frame_err} !== row) begin
            bad++;
            $display("FAIL sb_row: got tx/en/fe=%b%b%b want=%b at %0t",
                     TX_OUT, ser_en, frame_err, row, $time);
          end
        end
      end else begin
        total++;
        if (TX_OUT !== 1'b1 || ser_en !== 1'b0 || exp_q.size() != 0) begin
          bad++;
          $display("FAIL idle: tx=%b en=%b pending=%0d want tx=1 en=0 pending=0",
                   TX_OUT, ser_en, exp_q.size());
        end
      end
    end
  end

  // Caller sits at posedge+1. Waits for ready, strobes one request, queues its frame.
  task automatic send(input logic [7:0] b, input logic pe, input logic pt, input logic exp_par);
    int n;
    n = 0;
    while (!ready && n < 50) begin
      @(posedge CLK); #1; n++;
    end
    if (!ready) begin
      bad++; total++;
      $display("FAIL send_timeout: ready=%b want=1", ready);
    end
    P_DATA = b; PAR_EN = pe; PAR_TYP = pt; Data_Valid = 1'b1;
    @(posedge CLK); #1;
    Data_Valid = 1'b0;
    exp_loads++;
    exp_q.push_back(3'b010);
    for (int i = 0; i < 8; i++)
      exp_q.push_back({b[i], 1'b1, (stub_mode && i == 7)});
    if (pe) exp_q.push_back({exp_par, 2'b00});
    exp_q.push_back(3'b100);
    // Scramble config mid-frame; the frame in flight must not change.
    P_DATA = ~b; PAR_EN = ~pe; PAR_TYP = ~pt;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge CLK); #2; n++;
    end
    if (exp_q.size() != 0) begin
      bad++; total++;
      $display("FAIL %s_timeout: pending=%0d want=0", name, exp_q.size());
      exp_q.delete();
    end
    @(negedge CLK); #1;
    check({name, "_busy_low"}, int'(busy), 0);
    @(posedge CLK); #1;
  endtask

  initial begin
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_tx", int'(TX_OUT), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_ser_en", int'(ser_en), 0);
    check("rst_ready", int'(ready), 1);
    check("rst_frame_err", int'(frame_err), 0);
    RST = 1'b1;
    mon_en = 1'b1;
    @(posedge CLK); #1;

    // 0xA5 no parity: line 0,1,0,1,0,0,1,0,1,1
    send(8'hA5, 1'b0, 1'b0, 1'b0);
    wait_done("a5_np");
    send(8'hA5, 1'b1, 1'b0, 1'b0);
    wait_done("a5_even");
    send(8'hA5, 1'b1, 1'b1, 1'b1);
    wait_done("a5_odd");
    send(8'h07, 1'b1, 1'b0, 1'b1);
    wait_done("07_even");
    send(8'h07, 1'b1, 1'b1, 1'b0);
    wait_done("07_odd");

    // Back-to-back: second request lands in the first frame's STOP cycle.
    begin
      int l0;
      l0 = load_cnt;
      send(8'h55, 1'b0, 1'b0, 1'b0);
      send(8'h0F, 1'b0, 1'b0, 1'b0);
      wait_done("b2b");
      check("b2b_loads", load_cnt - l0, 2);
    end

    // Requests while not ready must be dropped.
    send(8'hA5, 1'b0, 1'b0, 1'b0);
    repeat (2) begin @(posedge CLK); #1; end
    Data_Valid = 1'b1;
    @(negedge CLK); #1;
    check("drop_c3_load", int'(ser_load), 0);
    @(posedge CLK); #1;
    Data_Valid = 1'b0;
    repeat (2) begin @(posedge CLK); #1; end
    Data_Valid = 1'b1;
    @(negedge CLK); #1;
    check("drop_c6_load", int'(ser_load), 0);
    @(posedge CLK); #1;
    Data_Valid = 1'b0;
    wait_done("drop");

    // Reset in cycle 5 aborts the frame.
    send(8'hA5, 1'b1, 1'b0, 1'b0);
    repeat (4) begin @(posedge CLK); #1; end
    RST = 1'b0;
    @(posedge CLK); #1;
    exp_q.delete();
    check("midrst_tx", int'(TX_OUT), 1);
    check("midrst_busy", int'(busy), 0);
    check("midrst_ser_en", int'(ser_en), 0);
    RST = 1'b1;
    @(posedge CLK); #1;

    // Serializer never raises ser_done.
    stub_mode = 1'b1;
    fe_cnt = 0;
    send(8'h3C, 1'b0, 1'b0, 1'b0);
    wait_done("stub");
    check("stub_fe_pulses", fe_cnt, 1);
    stub_mode = 1'b0;

    repeat (3) begin @(posedge CLK); #1; end
    check("total_loads", load_cnt, exp_loads);
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

Frame controller for the UART transmitter. Accepts a parallel byte, gates its load into the serializer, sequences start bit, 8 data bits from the serializer, optional parity bit and stop bit, and drives the serial line. Sits between the byte source and the serializer, and owns the TX line mux.

## Interface
- DATA_WIDTH, 8, frame data width. Must equal the serializer width; only 8 is supported.
- CLK  in  1  bit clock; one TX bit per CLK cycle.
- RST  in  1  synchronous, active-low reset.
- P_DATA  in  8  byte to send; sampled on the accept cycle.
- Data_Valid  in  1  request strobe; accepted only when `ready`.
- PAR_EN  in  1  1 = insert parity bit; latched at accept.
- PAR_TYP  in  1  0 = even, 1 = odd; latched at accept.
- ser_data  in  1  serializer serial output.
- ser_done  in  1  serializer last-bit flag; high together with bit 7 on `ser_data`.
- ser_load  out  1  load strobe to the serializer `Data_Valid`.
- ser_en  out  1  serializer enable.
- TX_OUT  out  1  serial line; idles high.
- busy  out  1  frame in progress.
- ready  out  1  request can be accepted this cycle.
- frame_err  out  1  one-cycle pulse when the serializer fails to report `ser_done`.

## Operation
- States: IDLE, START, DATA, PARITY, STOP. The state is registered. All other outputs decode combinationally from state and the internal registers.
- TX_OUT by state:
  - IDLE = 1, START = 0, DATA = `ser_data`.
  - PARITY = the latched parity bit, STOP = 1.
- `ser_en` = 1 exactly while state is START or DATA.
- `busy` = (state != IDLE).
- `ready` = state is IDLE or STOP.
- Accept: `accept = Data_Valid & ready`. `ser_load = accept` (combinational). Data_Valid outside `ready` is ignored and never reaches the serializer.
- On accept:
  - latch `par_en_r = PAR_EN`.
  - latch `par_bit = (^P_DATA) ^ PAR_TYP`.
  - clear `bit_cnt` (3 bits).
  - next state = START.
- START -> DATA unconditionally after 1 cycle.
- DATA, counting:
  - `bit_cnt` increments each cycle.
  - Exit when `ser_done = 1`: to PARITY if `par_en_r`, else to STOP.
- DATA, missing `ser_done`: if `bit_cnt == 7` and `ser_done = 0`, the controller still exits along the same path and pulses `frame_err` for that cycle.
- PARITY -> STOP after 1 cycle.
- STOP:
  - with accept -> START (back-to-back frame, no idle gap).
  - without accept -> IDLE.
- Config inputs change mid-frame: no effect on the current frame.

## Timing
- Reset (RST = 0 at an edge): state = IDLE, `par_en_r` = 0, `par_bit` = 0, `bit_cnt` = 0.
  - Hence TX_OUT = 1, `ser_en` = 0, `busy` = 0, `ready` = 1, `ser_load` = 0, `frame_err` = 0.
  - Reset mid-frame aborts at that edge. TX_OUT returns high with no stop bit.
- Accept at cycle 0 (IDLE):
  - START during cycle 1.
  - D0..D7 during cycles 2..9; `ser_done` is seen in cycle 9.
  - Parity in cycle 10 if enabled.
  - Stop in cycle 10 without parity, or cycle 11 with parity.
- Frame length on the line: 10 cycles without parity, 11 with parity.
- `ser_en` is high in cycles 1..9. The serializer's counter-8 wrap at the cycle-10 edge is expected and harmless.
- Back-to-back: Data_Valid in the STOP cycle makes the next cycle START. Continuous streaming is 10 or 11 cycles per byte.
- Data_Valid asserted for multiple cycles: one accept per `ready` window. Further cycles while not `ready` are dropped.

## Test plan
- Reset, RST low 2 cycles -> TX_OUT = 1, `busy` = 0, `ser_en` = 0, `ready` = 1. Hold reset mid-frame in cycle 5 -> next cycle IDLE, TX_OUT = 1.
- P_DATA = 0xA5, PAR_EN = 0 -> TX_OUT cycles 1..10 = 0,1,0,1,0,0,1,0,1,1. `busy` high in cycles 1..10, low in cycle 11.
- P_DATA = 0xA5, PAR_EN = 1: PAR_TYP = 0 -> parity in cycle 10 = 0; PAR_TYP = 1 -> parity = 1. Repeat with 0x07: even -> 1, odd -> 0. Stop in cycle 11.
- Back-to-back 0x55 then 0x0F, second Data_Valid in the first frame's STOP cycle -> second START immediately follows the stop bit. Exactly 2 `ser_load` pulses.
- Data_Valid pulsed in cycles 3 and 6 of a frame -> `ser_load` stays 0. The current frame's bits are unchanged.
- Stubbed serializer that never raises `ser_done` -> DATA lasts 8 cycles, `frame_err` pulses once in cycle 9, then STOP, then IDLE.
